// File: rtl/alu_rs_if.sv
// Dispatch, CDB and issue signals of the ALU reservation station.
// master = dispatcher/CDB side, slave = alu_rs.
`ifndef CalcCodeType
`define CalcCodeType 3:0
`endif
`ifndef WordType
`define WordType 31:0
`endif
`ifndef IqAddrType
`define IqAddrType 3:0
`endif

interface alu_rs_if;
    logic                 disp_enable_in;
    logic [`CalcCodeType] disp_calc_code_in;
    logic [`WordType]     disp_lhs_in;
    logic [`WordType]     disp_rhs_in;
    logic                 disp_lhs_ready_in;
    logic                 disp_rhs_ready_in;
    logic [`IqAddrType]   disp_lhs_tag_in;
    logic [`IqAddrType]   disp_rhs_tag_in;
    logic [`IqAddrType]   disp_pos_in_iq_in;
    logic                 cdb_enable_in;
    logic [`IqAddrType]   cdb_tag_in;
    logic [`WordType]     cdb_value_in;
    logic                 full_out;
    logic                 calc_enable_out;
    logic [`CalcCodeType] calc_code_out;
    logic [`WordType]     lhs_out;
    logic [`WordType]     rhs_out;
    logic [`IqAddrType]   pos_in_iq_out;

    modport master (
        output disp_enable_in, disp_calc_code_in, disp_lhs_in, disp_rhs_in,
               disp_lhs_ready_in, disp_rhs_ready_in, disp_lhs_tag_in, disp_rhs_tag_in,
               disp_pos_in_iq_in, cdb_enable_in, cdb_tag_in, cdb_value_in,
        input  full_out, calc_enable_out, calc_code_out, lhs_out, rhs_out, pos_in_iq_out
    );

    modport slave (
        input  disp_enable_in, disp_calc_code_in, disp_lhs_in, disp_rhs_in,
               disp_lhs_ready_in, disp_rhs_ready_in, disp_lhs_tag_in, disp_rhs_tag_in,
               disp_pos_in_iq_in, cdb_enable_in, cdb_tag_in, cdb_value_in,
        output full_out, calc_enable_out, calc_code_out, lhs_out, rhs_out, pos_in_iq_out
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds ops until operands arrive, issues lowest ready entry per update edge.
// Optional ALU_RS_BYPASS_EN: a dispatched operand also captures a same-edge CDB broadcast.
`ifndef CalcCodeType
`define CalcCodeType 3:0
`endif
`ifndef WordType
`define WordType 31:0
`endif
`ifndef IqAddrType
`define IqAddrType 3:0
`endif

module alu_rs #(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     update_stat,
    input  logic     clear_flag_in,
    alu_rs_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   qj_busy;
    logic [RS_SIZE-1:0]   qk_busy;
    logic [`CalcCodeType] code [RS_SIZE];
    logic [`WordType]     vj   [RS_SIZE];
    logic [`WordType]     vk   [RS_SIZE];
    logic [`IqAddrType]   qj   [RS_SIZE];
    logic [`IqAddrType]   qk   [RS_SIZE];
    logic [`IqAddrType]   pos  [RS_SIZE];

    logic [RS_SIZE-1:0]   ready;
    logic                 issue_found;
    logic                 free_found;
    logic [IDX_W-1:0]     issue_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 new_lhs_wait;
    logic                 new_rhs_wait;
    logic [`WordType]     new_lhs;
    logic [`WordType]     new_rhs;

    assign ready        = busy & ~qj_busy & ~qk_busy;
    assign bus.full_out = &busy;

    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && !issue_found) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
`ifdef ALU_RS_BYPASS_EN
        new_lhs_wait = !bus.disp_lhs_ready_in &&
                       !(bus.cdb_enable_in && bus.cdb_tag_in == bus.disp_lhs_tag_in);
        new_rhs_wait = !bus.disp_rhs_ready_in &&
                       !(bus.cdb_enable_in && bus.cdb_tag_in == bus.disp_rhs_tag_in);
        new_lhs      = bus.disp_lhs_ready_in ? bus.disp_lhs_in : bus.cdb_value_in;
        new_rhs      = bus.disp_rhs_ready_in ? bus.disp_rhs_in : bus.cdb_value_in;
`else
        new_lhs_wait = !bus.disp_lhs_ready_in;
        new_rhs_wait = !bus.disp_rhs_ready_in;
        new_lhs      = bus.disp_lhs_in;
        new_rhs      = bus.disp_rhs_in;
`endif
    end

    // Issue, capture and dispatch never target the same entry, so their writes do not collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy                <= '0;
            qj_busy             <= '0;
            qk_busy             <= '0;
            bus.calc_enable_out <= 1'b0;
            bus.calc_code_out   <= '0;
            bus.lhs_out         <= '0;
            bus.rhs_out         <= '0;
            bus.pos_in_iq_out   <= '0;
        end else if (rdy && !update_stat) begin
            if (clear_flag_in) begin
                busy                <= '0;
                bus.calc_enable_out <= 1'b0;
            end else begin
                bus.calc_enable_out <= issue_found;
                if (issue_found) begin
                    bus.calc_code_out <= code[issue_idx];
                    bus.lhs_out       <= vj[issue_idx];
                    bus.rhs_out       <= vk[issue_idx];
                    bus.pos_in_iq_out <= pos[issue_idx];
                    busy[issue_idx]   <= 1'b0;
                end
                if (bus.cdb_enable_in) begin
                    for (int unsigned i = 0; i < RS_SIZE; i++) begin
                        if (busy[i] && qj_busy[i] && qj[i] == bus.cdb_tag_in) begin
                            vj[i]      <= bus.cdb_value_in;
                            qj_busy[i] <= 1'b0;
                        end
                        if (busy[i] && qk_busy[i] && qk[i] == bus.cdb_tag_in) begin
                            vk[i]      <= bus.cdb_value_in;
                            qk_busy[i] <= 1'b0;
                        end
                    end
                end
                if (bus.disp_enable_in && !bus.full_out && free_found) begin
                    busy[free_idx]    <= 1'b1;
                    code[free_idx]    <= bus.disp_calc_code_in;
                    vj[free_idx]      <= new_lhs;
                    vk[free_idx]      <= new_rhs;
                    qj_busy[free_idx] <= new_lhs_wait;
                    qk_busy[free_idx] <= new_rhs_wait;
                    qj[free_idx]      <= bus.disp_lhs_tag_in;
                    qk[free_idx]      <= bus.disp_rhs_tag_in;
                    pos[free_idx]     <= bus.disp_pos_in_iq_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed literal checks plus randomized traffic against an entry-list model.
`ifndef CalcCodeType
`define CalcCodeType 3:0
`endif
`ifndef WordType
`define WordType 31:0
`endif
`ifndef IqAddrType
`define IqAddrType 3:0
`endif

module tb_alu_rs;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic update_stat = 1'b0;
    logic clear_flag_in = 1'b0;

    alu_rs_if bus();

    alu_rs #(.RS_SIZE(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .update_stat  (update_stat),
        .clear_flag_in(clear_flag_in),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        busy;
        bit [3:0]  code;
        bit [31:0] a;
        bit [31:0] b;
        bit        wa;
        bit        wb;
        bit [3:0]  ta;
        bit [3:0]  tb;
        bit [3:0]  pos;
    } ent_t;

    ent_t      m [N];
    bit        e_en;
    bit [3:0]  e_code;
    bit [31:0] e_lhs;
    bit [31:0] e_rhs;
    bit [3:0]  e_pos;
    bit        check_on = 1'b0;
    int        errors = 0;
    int        checks = 0;

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < N; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    // Behavioural view: an entry list; decisions use the snapshot taken before the edge.
    task automatic model_step();
        ent_t old [N];
        int   iss;
        int   fr;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m[i].busy = 1'b0; m[i].wa = 1'b0; m[i].wb = 1'b0;
            end
            e_en = 1'b0; e_code = '0; e_lhs = '0; e_rhs = '0; e_pos = '0;
        end else if (rdy && !update_stat) begin
            if (clear_flag_in) begin
                for (int i = 0; i < N; i++) m[i].busy = 1'b0;
                e_en = 1'b0;
            end else begin
                old = m;
                iss = -1;
                fr  = -1;
                for (int i = 0; i < N; i++) begin
                    if (iss < 0 && old[i].busy && !old[i].wa && !old[i].wb) iss = i;
                    if (fr < 0 && !old[i].busy) fr = i;
                end
                e_en = (iss >= 0);
                if (iss >= 0) begin
                    e_code = old[iss].code; e_lhs = old[iss].a;
                    e_rhs  = old[iss].b;    e_pos = old[iss].pos;
                    m[iss].busy = 1'b0;
                end
                if (bus.cdb_enable_in) begin
                    for (int i = 0; i < N; i++) begin
                        if (old[i].busy && old[i].wa && old[i].ta == bus.cdb_tag_in) begin
                            m[i].a = bus.cdb_value_in; m[i].wa = 1'b0;
                        end
                        if (old[i].busy && old[i].wb && old[i].tb == bus.cdb_tag_in) begin
                            m[i].b = bus.cdb_value_in; m[i].wb = 1'b0;
                        end
                    end
                end
                if (bus.disp_enable_in && fr >= 0) begin
                    m[fr].busy = 1'b1;
                    m[fr].code = bus.disp_calc_code_in;
                    m[fr].a    = bus.disp_lhs_in;
                    m[fr].b    = bus.disp_rhs_in;
                    m[fr].wa   = !bus.disp_lhs_ready_in;
                    m[fr].wb   = !bus.disp_rhs_ready_in;
                    m[fr].ta   = bus.disp_lhs_tag_in;
                    m[fr].tb   = bus.disp_rhs_tag_in;
                    m[fr].pos  = bus.disp_pos_in_iq_in;
`ifdef ALU_RS_BYPASS_EN
                    if (bus.cdb_enable_in && m[fr].wa && m[fr].ta == bus.cdb_tag_in) begin
                        m[fr].a = bus.cdb_value_in; m[fr].wa = 1'b0;
                    end
                    if (bus.cdb_enable_in && m[fr].wb && m[fr].tb == bus.cdb_tag_in) begin
                        m[fr].b = bus.cdb_value_in; m[fr].wb = 1'b0;
                    end
`endif
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            chk("calc_enable_out", bus.calc_enable_out, e_en);
            chk("calc_code_out",   bus.calc_code_out,   e_code);
            chk("lhs_out",         bus.lhs_out,         e_lhs);
            chk("rhs_out",         bus.rhs_out,         e_rhs);
            chk("pos_in_iq_out",   bus.pos_in_iq_out,   e_pos);
            chk("full_out",        bus.full_out,        m_full());
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic upd_edge();
        update_stat = 1'b0; step();
        update_stat = 1'b1; step();
    endtask

    task automatic idle();
        bus.disp_enable_in = 1'b0;
        bus.cdb_enable_in  = 1'b0;
        clear_flag_in      = 1'b0;
    endtask

    task automatic disp(input logic [3:0] code, input logic lr, input logic [31:0] lv,
                        input logic [3:0] lt, input logic rr, input logic [31:0] rv,
                        input logic [3:0] rt, input logic [3:0] p);
        bus.disp_enable_in    = 1'b1;
        bus.disp_calc_code_in = code;
        bus.disp_lhs_ready_in = lr; bus.disp_lhs_in = lv; bus.disp_lhs_tag_in = lt;
        bus.disp_rhs_ready_in = rr; bus.disp_rhs_in = rv; bus.disp_rhs_tag_in = rt;
        bus.disp_pos_in_iq_in = p;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        bus.cdb_enable_in = 1'b1; bus.cdb_tag_in = t; bus.cdb_value_in = v;
    endtask

    initial begin
        idle();
        disp(0, 1, 0, 0, 1, 0, 0, 0);
        bus.disp_enable_in = 1'b0;
        cdb(0, 0);
        bus.cdb_enable_in = 1'b0;

        // Reset
        rst = 1'b0; update_stat = 1'b0;
        step();
        check_on = 1'b1;
        step();
        chk("rst_en", bus.calc_enable_out, 0);
        chk("rst_lhs", bus.lhs_out, 0);
        chk("rst_full", bus.full_out, 0);
        rst = 1'b1;

        // Ready operands issue one update edge after dispatch
        disp(0, 1, 5, 0, 1, 7, 0, 1);
        upd_edge(); idle();
        chk("d1_no_issue_yet", bus.calc_enable_out, 0);
        upd_edge();
        chk("d1_en", bus.calc_enable_out, 1);
        chk("d1_lhs", bus.lhs_out, 5);
        chk("d1_rhs", bus.rhs_out, 7);
        chk("d1_code", bus.calc_code_out, 0);
        upd_edge();
        chk("d1_deassert", bus.calc_enable_out, 0);

        // CDB wake-up
        disp(1, 0, 0, 3, 1, 2, 0, 2);
        upd_edge(); idle();
        upd_edge();
        chk("d2_wait", bus.calc_enable_out, 0);
        cdb(3, 10);
        upd_edge(); idle();
        chk("d2_capture_edge", bus.calc_enable_out, 0);
        upd_edge();
        chk("d2_en", bus.calc_enable_out, 1);
        chk("d2_lhs", bus.lhs_out, 10);
        chk("d2_rhs", bus.rhs_out, 2);
        chk("d2_code", bus.calc_code_out, 1);

        // Fill, drop when full, then drain in index order
        for (int i = 0; i < N; i++) begin
            disp(4'(i), 0, 0, 4, 1, 32'(i), 0, 4'(i));
            upd_edge();
        end
        idle();
        chk("fill_full", bus.full_out, 1);
        disp(9, 1, 99, 0, 1, 99, 0, 15);
        upd_edge(); idle();
        chk("fill_still_full", bus.full_out, 1);
        cdb(4, 100);
        upd_edge(); idle();
        for (int k = 0; k < N; k++) begin
            upd_edge();
            chk("drain_en", bus.calc_enable_out, 1);
            chk("drain_pos", bus.pos_in_iq_out, 4'(k));
            chk("drain_rhs", bus.rhs_out, 32'(k));
            chk("drain_lhs", bus.lhs_out, 100);
            chk("drain_full", bus.full_out, 0);
        end
        upd_edge();
        chk("drain_done", bus.calc_enable_out, 0);

        // Flush beats dispatch and CDB
        for (int i = 0; i < 3; i++) begin
            disp(2, 0, 0, 9, 1, 1, 0, 4'(i)); upd_edge();
        end
        disp(3, 1, 1, 0, 1, 1, 0, 7); cdb(9, 55); clear_flag_in = 1'b1;
        upd_edge(); idle();
        chk("clr_en", bus.calc_enable_out, 0);
        chk("clr_full", bus.full_out, 0);
        cdb(9, 55); upd_edge(); idle();
        upd_edge();
        chk("clr_nothing", bus.calc_enable_out, 0);

        // Hold behaviour and mid-sequence reset
        disp(2, 1, 32'h11, 0, 1, 32'h22, 0, 5); cdb(1, 1);
        update_stat = 1'b1; step(); step();
        rdy = 1'b0; update_stat = 1'b0; step(); step();
        rdy = 1'b1; idle();
        upd_edge(); upd_edge();
        chk("hold_no_dispatch", bus.calc_enable_out, 0);
        disp(3, 1, 32'h33, 0, 1, 1, 0, 6); upd_edge(); idle(); upd_edge();
        chk("hold_pre_en", bus.calc_enable_out, 1);
        rdy = 1'b0; update_stat = 1'b0; step(); step(); rdy = 1'b1;
        chk("hold_en", bus.calc_enable_out, 1);
        chk("hold_lhs", bus.lhs_out, 32'h33);
        disp(5, 0, 0, 2, 1, 1, 0, 3); upd_edge();
        disp(6, 1, 32'h44, 0, 1, 2, 0, 4); upd_edge(); idle(); upd_edge();
        chk("mid_en", bus.lhs_out, 32'h44);
        rst = 1'b0; step(); rst = 1'b1;
        chk("mrst_en", bus.calc_enable_out, 0);
        chk("mrst_lhs", bus.lhs_out, 0);
        chk("mrst_pos", bus.pos_in_iq_out, 0);
        cdb(2, 8); upd_edge(); idle(); upd_edge();
        chk("mrst_discard", bus.calc_enable_out, 0);

        // Same-edge CDB during dispatch
        disp(4, 0, 0, 6, 1, 1, 0, 6); cdb(6, 32'hFF);
        upd_edge(); idle(); upd_edge();
`ifdef ALU_RS_BYPASS_EN
        chk("byp_en", bus.calc_enable_out, 1);
        chk("byp_lhs", bus.lhs_out, 32'hFF);
`else
        chk("nobyp_wait", bus.calc_enable_out, 0);
`endif
        clear_flag_in = 1'b1; upd_edge(); idle();

        // Randomized traffic
        repeat (3000) begin
            if ($urandom_range(0, 3) != 0) update_stat = !update_stat;
            rdy           = ($urandom_range(0, 9) != 0);
            rst           = ($urandom_range(0, 149) != 0);
            clear_flag_in = ($urandom_range(0, 39) == 0);
            disp(4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0), $urandom,
                 4'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0), $urandom,
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            bus.disp_enable_in = !m_full() && ($urandom_range(0, 1) != 0);
            cdb(4'($urandom_range(0, 3)), $urandom);
            bus.cdb_enable_in = ($urandom_range(0, 2) == 0);
            step();
        end
        idle();
        rst = 1'b1;
        step();

        check_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station. Holds dispatched ALU operations until both operands are available. Captures operands broadcast on the CDB. Issues one ready operation per phase-0 cycle to the ALU stage through its `rs_*` inputs. Sits between the dispatch/decode stage and the ALU.

## Interface
- `RS_SIZE`, default 8: number of entries; must be a power of two, minimum 2.
- `clk` input 1: clock.
- `rst` input 1: synchronous active-low reset. Sampled on the `clk` rising edge; 0 means reset.
- `rdy` input 1: global ready. When 0, all state and outputs hold.
- `update_stat` input 1: phase flag. 0 is the update phase; 1 is the ALU sampling phase.
- `clear_flag_in` input 1: misprediction flush.
- `disp_enable_in` input 1: dispatch request.
- `disp_calc_code_in` input `CalcCodeType: operation code, 0..15.
- `disp_lhs_in` / `disp_rhs_in` input `WordType: operand values, valid when ready.
- `disp_lhs_ready_in` / `disp_rhs_ready_in` input 1: operand already available.
- `disp_lhs_tag_in` / `disp_rhs_tag_in` input `IqAddrType: producer IQ index, used when not ready.
- `disp_pos_in_iq_in` input `IqAddrType: IQ index of the dispatched instruction.
- `cdb_enable_in` input 1, `cdb_tag_in` input `IqAddrType, `cdb_value_in` input `WordType: result broadcast.
- `full_out` output 1: no free entry. Combinational from registered busy bits.
- `calc_enable_out` output 1: issue valid. Drives the ALU `rs_calc_enable_in`.
- `calc_code_out` output `CalcCodeType; `lhs_out` / `rhs_out` output `WordType; `pos_in_iq_out` output `IqAddrType: registered issue payload.

## Operation
- Each entry holds: busy, calc code, vj, vk, qj_busy, qj, qk_busy, qk, pos.
- An entry is ready when busy, !qj_busy and !qk_busy.
- All state changes occur only on edges with `rst`=1, `rdy`=1 and `update_stat`=0, called "update edges" below.
- On edges with `update_stat`=1, everything holds, so the ALU samples a stable payload.
- Precedence on an update edge:
  1. If `clear_flag_in`=1, all busy bits become 0 and `calc_enable_out` becomes 0. Dispatch and CDB are ignored.
  2. Otherwise, the issue, CDB capture and dispatch below happen in parallel, all evaluated on pre-edge state.
- Issue:
  - Select the lowest-index ready entry.
  - Register its code, vj, vk and pos into the outputs, set `calc_enable_out`=1, and clear its busy bit.
  - If no entry is ready, `calc_enable_out` becomes 0 and the payload holds.
- CDB capture: when `cdb_enable_in`=1, every busy entry with qj_busy and qj==`cdb_tag_in` loads vj=`cdb_value_in` and clears qj_busy. The same applies to qk.
- Dispatch:
  - When `disp_enable_in`=1 and `full_out`=0, write the lowest-index non-busy entry (pre-edge) and set it busy.
  - An entry freed by issue on the same edge is not reusable until the next update edge.
  - Dispatch while `full_out`=1 is dropped. The dispatcher must not issue a request in that case.
- `full_out` = (busy count == `RS_SIZE`), evaluated on current registered state.
- Reset (`rst`=0 on an edge) sets:
  - all busy bits 0, all qj_busy/qk_busy 0;
  - `calc_enable_out`=0, `calc_code_out`=0, `lhs_out`=0, `rhs_out`=0, `pos_in_iq_out`=0;
  - therefore `full_out`=0.
- Reset has priority over `rdy`. Reset mid-operation discards all entries.

## Timing
- Dispatch on update edge k with both operands ready: issue payload is valid after update edge k+1. The ALU samples it at the following `update_stat`=1 edge.
- An operand woken by the CDB on update edge k is visible to the ready check at update edge k+1. The earliest issue is therefore on that edge.
- `calc_enable_out` is asserted for exactly one update-to-update interval per issued entry. It is deasserted on the next update edge unless another entry issues.
- The ALU drains its result on every update edge. The station therefore never stalls on the ALU: one issue per update edge, sustained.
- Issue, capture and dispatch on the same edge never touch the same entry:
  - the issued entry is busy;
  - the dispatch target is non-busy;
  - capture only writes busy entries.

## Configuration
- `ALU_RS_BYPASS_EN` defined: on a dispatch edge, each non-ready operand whose tag equals `cdb_tag_in` while `cdb_enable_in`=1 is written as ready with value `cdb_value_in`.
- `ALU_RS_BYPASS_EN` undefined: that broadcast is missed by the new entry. Upstream must then present the operand as ready, from the IQ result field, on that dispatch.

## Test plan
- Reset, then dispatch code 0 with lhs=5 and rhs=7, both ready: after the next update edge, `calc_enable_out`=1, `lhs_out`=5, `rhs_out`=7, `calc_code_out`=0. On the following update edge, `calc_enable_out`=0.
- Dispatch code 1 with lhs tag 3 not ready and rhs=2 ready: there is no issue. Then CDB tag 3 with value 10 arrives. One update edge later, issue with `lhs_out`=10 and `rhs_out`=2.
- Dispatch `RS_SIZE` entries, all waiting on tag 4: `full_out`=1, and a further dispatch is dropped. CDB tag 4 then wakes all entries. They issue in index order 0..7 on consecutive update edges, and `full_out` clears after the first issue.
- With 3 busy entries, assert `clear_flag_in` together with a dispatch and a CDB broadcast: all entries are freed, `calc_enable_out`=0, `full_out`=0, and nothing is written.
- Hold `update_stat`=1 or `rdy`=0 during dispatch and CDB activity: no state changes. Assert `rst`=0 mid-sequence: all outputs return to 0.
- With `ALU_RS_BYPASS_EN` defined, dispatch with lhs tag 6 not ready in the same edge as CDB tag 6 with value 0xFF: issue next update edge with `lhs_out`=0xFF. With the macro undefined, the entry stays waiting.
